// File: rtl/rv32v_hazard_pkg.sv
// Shared types and default stage indices for the RV32V hazard controller.
package rv32v_hazard_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2,
      ABORT  = 2'd3
   } hzd_state_t;

   localparam int DEC_STAGE_DEF = 2;
   localparam int CSR_STAGE_DEF = 4;

endpackage

// File: rtl/rv32v_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle; the pipeline is the master, the controller the slave.
interface rv32v_hazard_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int VQ_DEPTH   = 4
);
   localparam int CNT_W = $clog2(VQ_DEPTH + 1);

   logic [NUM_STAGES-1:0] busy;
   logic [NUM_STAGES-1:0] exception;
   logic                  csr_update;
   logic                  v_start;
   logic                  v_done;
   logic [NUM_STAGES-1:0] stall;
   logic [NUM_STAGES-1:0] flush;
   logic                  v_busy;
   logic                  v_decode_done;
   logic                  v_kill;
   logic [CNT_W-1:0]      v_count;
   logic                  v_underflow;
   logic                  wdt_timeout;

   modport master (
      output busy, exception, csr_update, v_start, v_done,
      input  stall, flush, v_busy, v_decode_done, v_kill, v_count, v_underflow, wdt_timeout
   );

   modport slave (
      input  busy, exception, csr_update, v_start, v_done,
      output stall, flush, v_busy, v_decode_done, v_kill, v_count, v_underflow, wdt_timeout
   );

endinterface

// File: rtl/rv32v_vq_credit.sv
// Vector-op credit window: accept logic, outstanding counter, underflow flag and window FSM.
// Optional watchdog built when RV32V_HAZARD_WATCHDOG_EN is defined.
module rv32v_vq_credit
   import rv32v_hazard_pkg::*;
#(
   parameter  int VQ_DEPTH  = 4,
   parameter  int WDT_LIMIT = 1024,
   localparam int CNT_W     = $clog2(VQ_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             v_start,
   input  logic             v_done,
   input  logic             dec_blocked,
   input  logic             exc_any,
   output hzd_state_t       state,
   output logic [CNT_W-1:0] v_count,
   output logic             v_busy,
   output logic             acc,
   output logic             v_kill,
   output logic             v_underflow,
   output logic             wdt_timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VQ_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   if (VQ_DEPTH < 1 || VQ_DEPTH > 15 || WDT_LIMIT < 1) begin : g_bad_param
      $error("rv32v_vq_credit: VQ_DEPTH must be 1..15 and WDT_LIMIT >= 1");
   end

   hzd_state_t       state_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             uf_set;
   logic             wdt_hit;

   assign v_busy = (v_count == CNT_MAX) || (state == FULL);
   assign v_kill = (state == ABORT);
   assign acc    = v_start && !dec_blocked && (state != ABORT) && (v_count < CNT_MAX);

   // A v_done that meets an accept in the same cycle cancels it; neither moves the count.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      count_nxt = v_count;
      uf_set    = 1'b0;
      if (state == ABORT) begin
         count_nxt = '0;
      end else if (acc && !v_done) begin
         count_nxt = v_count + CNT_ONE;
      end else if (v_done && !acc) begin
         if (v_count != '0) count_nxt = v_count - CNT_ONE;
         else               uf_set    = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == ABORT) begin
         state_nxt = IDLE;
      end else if ((exc_any && (v_count != '0 || acc)) || wdt_hit) begin
         state_nxt = ABORT;
      end else begin
         case (state)
            IDLE:    if (count_nxt != '0) state_nxt = ACTIVE;
            ACTIVE:  if (count_nxt == CNT_MAX) state_nxt = FULL;
                     else if (count_nxt == '0) state_nxt = IDLE;
            FULL:    if (v_done && !acc) state_nxt = ACTIVE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state       <= IDLE;
         v_count     <= '0;
         v_underflow <= 1'b0;
      end else begin
         state   <= state_nxt;
         v_count <= count_nxt;
         if (uf_set) v_underflow <= 1'b1;
      end
   end

`ifdef RV32V_HAZARD_WATCHDOG_EN
   localparam int               WDT_W    = $clog2(WDT_LIMIT + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
   localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

   logic [WDT_W-1:0] wdt_cnt;
   logic             running;

   assign running = (state == ACTIVE) || (state == FULL);
   assign wdt_hit = running && !v_done && (wdt_cnt == WDT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt     <= '0;
         wdt_timeout <= 1'b0;
      end else begin
         if (!running || v_done || wdt_hit) wdt_cnt <= '0;
         else                               wdt_cnt <= wdt_cnt + WDT_ONE;
         if (wdt_hit) wdt_timeout <= 1'b1;
      end
   end
`else
   assign wdt_hit     = 1'b0;
   assign wdt_timeout = 1'b0;
`endif

endmodule

// File: rtl/rv32v_hazard_ctrl.sv
// Parametrised stall/flush controller for the vector RV32 pipeline (stage 0 = oldest fetch).
// Optional watchdog: define RV32V_HAZARD_WATCHDOG_EN.
module rv32v_hazard_ctrl
   import rv32v_hazard_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int DEC_STAGE  = DEC_STAGE_DEF,
   parameter int CSR_STAGE  = CSR_STAGE_DEF,
   parameter int VQ_DEPTH   = 4,
   parameter int WDT_LIMIT  = 1024
) (
   input logic                CLK,
   input logic                RST,
   rv32v_hazard_ctrl_if.slave hz
);

   if (NUM_STAGES < 3 || DEC_STAGE >= CSR_STAGE || CSR_STAGE >= NUM_STAGES) begin : g_bad_param
      $error("rv32v_hazard_ctrl: need NUM_STAGES >= 3 and DEC_STAGE < CSR_STAGE < NUM_STAGES");
   end

   hzd_state_t            state;
   logic                  v_busy;
   logic [NUM_STAGES-1:0] stall_raw;
   logic [NUM_STAGES-1:0] flush_all;
   logic                  dec_blocked;

   // Both masks are suffix ORs: a stage holds for any busy stage ahead of it and
   // squashes when it or anything ahead of it faults.
   always_comb begin
      logic busy_ahead;
      logic exc_ahead;
      busy_ahead = 1'b0;
      exc_ahead  = 1'b0;
      stall_raw  = '0;
      flush_all  = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         stall_raw[i] = busy_ahead;
         busy_ahead   = busy_ahead | hz.busy[i];
         exc_ahead    = exc_ahead | hz.exception[i];
         flush_all[i] = exc_ahead | (hz.csr_update && (i < CSR_STAGE));
      end
      if (v_busy || state == ABORT) begin
         for (int i = 0; i <= DEC_STAGE; i++) stall_raw[i] = 1'b1;
      end
   end

   // Outputs read zero throughout reset, including the purely combinational ones.
   assign hz.stall     = RST ? '0 : (stall_raw & ~flush_all);
   assign hz.flush     = RST ? '0 : flush_all;
   assign hz.v_busy    = v_busy;
   assign dec_blocked  = RST | stall_raw[DEC_STAGE] | flush_all[DEC_STAGE];

   rv32v_vq_credit #(
      .VQ_DEPTH  (VQ_DEPTH),
      .WDT_LIMIT (WDT_LIMIT)
   ) u_vq_credit (
      .clk         (CLK),
      .rst         (RST),
      .v_start     (hz.v_start),
      .v_done      (hz.v_done),
      .dec_blocked (dec_blocked),
      .exc_any     (|hz.exception),
      .state       (state),
      .v_count     (hz.v_count),
      .v_busy      (v_busy),
      .acc         (hz.v_decode_done),
      .v_kill      (hz.v_kill),
      .v_underflow (hz.v_underflow),
      .wdt_timeout (hz.wdt_timeout)
   );

endmodule

// File: tb/tb_rv32v_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_rv32v_hazard_ctrl;

   localparam int NS  = 5;
   localparam int DEC = 2;
   localparam int CSR = 4;
   localparam int VQ  = 4;
`ifdef RV32V_HAZARD_WATCHDOG_EN
   localparam int WDT_LIM = 16;
`else
   localparam int WDT_LIM = 1024;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   rv32v_hazard_ctrl_if #(.NUM_STAGES(NS), .VQ_DEPTH(VQ)) hz ();

   rv32v_hazard_ctrl #(
      .NUM_STAGES (NS),
      .DEC_STAGE  (DEC),
      .CSR_STAGE  (CSR),
      .VQ_DEPTH   (VQ),
      .WDT_LIMIT  (WDT_LIM)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: number of ops in the window, whether this cycle is the abort cycle,
   // sticky flags, and how long the window has been open without a completion.
   int      m_count;
   bit      m_abort;
   bit      m_uf;
   bit      m_wdt;
   int      m_quiet;
   logic [NS-1:0] e_stall;
   logic [NS-1:0] e_flush;
   bit      e_acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_abort = 0;
      m_uf    = 0;
      m_wdt   = 0;
      m_quiet = 0;
   endtask

   task automatic idle_inputs();
      hz.busy       = '0;
      hz.exception  = '0;
      hz.csr_update = 1'b0;
      hz.v_start    = 1'b0;
      hz.v_done     = 1'b0;
   endtask

   task automatic model_comb();
      logic [NS-1:0] s;
      logic [NS-1:0] f;
      s = '0;
      f = '0;
      for (int i = 0; i < NS; i++)
         for (int j = i + 1; j < NS; j++)
            if (hz.busy[j]) s[i] = 1'b1;
      if (m_count == VQ || m_abort)
         for (int i = 0; i <= DEC; i++) s[i] = 1'b1;
      for (int i = 0; i < NS; i++)
         if (hz.exception[i])
            for (int j = 0; j <= i; j++) f[j] = 1'b1;
      if (hz.csr_update)
         for (int i = 0; i < CSR; i++) f[i] = 1'b1;
      e_acc   = hz.v_start && !s[DEC] && !f[DEC] && !m_abort && (m_count < VQ);
      e_stall = s & ~f;
      e_flush = f;
   endtask

   task automatic model_seq();
      bit wdt_fire;
      bit go_abort;
      wdt_fire = 0;
      if (m_abort) begin
         m_count = 0;
         m_abort = 0;
         m_quiet = 0;
      end else begin
`ifdef RV32V_HAZARD_WATCHDOG_EN
         if (m_count > 0 && !hz.v_done) begin
            m_quiet++;
            if (m_quiet == WDT_LIM) begin
               wdt_fire = 1;
               m_wdt    = 1;
            end
         end else begin
            m_quiet = 0;
         end
`endif
         go_abort = ((hz.exception != '0) && (m_count > 0 || e_acc)) || wdt_fire;
         if (e_acc && !hz.v_done) m_count++;
         else if (hz.v_done && !e_acc) begin
            if (m_count > 0) m_count--;
            else             m_uf = 1;
         end
         m_abort = go_abort;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_comb();
      check("stall", 32'(hz.stall), 32'(e_stall));
      check("flush", 32'(hz.flush), 32'(e_flush));
      check("v_decode_done", 32'(hz.v_decode_done), 32'(e_acc));
      check("v_busy", 32'(hz.v_busy), 32'(m_count == VQ));
      check("v_kill", 32'(hz.v_kill), 32'(m_abort));
      check("v_count", 32'(hz.v_count), 32'(m_count));
      check("v_underflow", 32'(hz.v_underflow), 32'(m_uf));
      check("wdt_timeout", 32'(hz.wdt_timeout), 32'(m_wdt));
   endtask

   task automatic advance();
      @(posedge clk);
      model_seq();
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, 32'(hz.stall), 0);
      check({tag, "_flush"}, 32'(hz.flush), 0);
      check({tag, "_decode_done"}, 32'(hz.v_decode_done), 0);
      check({tag, "_v_busy"}, 32'(hz.v_busy), 0);
      check({tag, "_v_kill"}, 32'(hz.v_kill), 0);
      check({tag, "_v_count"}, 32'(hz.v_count), 0);
      check({tag, "_underflow"}, 32'(hz.v_underflow), 0);
      check({tag, "_wdt"}, 32'(hz.wdt_timeout), 0);
   endtask

   initial begin
      int seen;

      // Reset with every input asserted: all outputs must still read zero.
      hz.busy = '1; hz.exception = '1; hz.csr_update = 1'b1; hz.v_start = 1'b1; hz.v_done = 1'b1;
      #3;
      check_all_zero("reset");
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      // Busy stage 3 holds everything older than it.
      hz.busy = 5'b01000;
      settle(); check("t1_stall", 32'(hz.stall), 32'h07); check("t1_flush", 32'(hz.flush), 0);
      advance();
      hz.busy = '0;
      settle(); check("t1_stall_clear", 32'(hz.stall), 0);
      advance();

      // Fill the window, confirm the fifth op is refused, then retire one.
      hz.v_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle(); check("t2_accept", 32'(hz.v_decode_done), 1);
         advance();
      end
      settle();
      check("t2_count_full", 32'(hz.v_count), 4);
      check("t2_busy", 32'(hz.v_busy), 1);
      check("t2_stall_dec", 32'(hz.stall), 32'h07);
      check("t2_refused", 32'(hz.v_decode_done), 0);
      advance();
      hz.v_start = 1'b0; hz.v_done = 1'b1;
      step();
      hz.v_done = 1'b0;
      settle(); check("t2_count_3", 32'(hz.v_count), 3); check("t2_busy_clear", 32'(hz.v_busy), 0);
      advance();

      // Simultaneous accept and retire leaves the count unchanged.
      hz.v_done = 1'b1;
      step();
      hz.v_start = 1'b1;
      settle(); check("t3_accept", 32'(hz.v_decode_done), 1);
      advance();
      hz.v_start = 1'b0; hz.v_done = 1'b0;
      settle(); check("t3_count", 32'(hz.v_count), 2);
      advance();

      // Exception at stage 3 with ops in flight: flush then a one-cycle abort.
      hz.v_start = 1'b1;
      step();
      hz.v_start = 1'b0; hz.exception = 5'b01000;
      settle(); check("t4_flush", 32'(hz.flush), 32'h0F); check("t4_count", 32'(hz.v_count), 3);
      advance();
      hz.exception = '0; hz.v_done = 1'b1;
      settle(); check("t4_kill", 32'(hz.v_kill), 1); check("t4_abort_stall", 32'(hz.stall), 32'h07);
      advance();
      hz.v_done = 1'b0;
      settle();
      check("t4_kill_off", 32'(hz.v_kill), 0);
      check("t4_count_cleared", 32'(hz.v_count), 0);
      check("t4_no_underflow", 32'(hz.v_underflow), 0);
      advance();

      // Underflow is sticky; CSR commit flushes the older stages.
      hz.v_done = 1'b1;
      step();
      hz.v_done = 1'b0; hz.csr_update = 1'b1;
      settle(); check("t5_underflow", 32'(hz.v_underflow), 1); check("t5_csr_flush", 32'(hz.flush), 32'h0F);
      advance();
      hz.csr_update = 1'b0; hz.exception = 5'b10000;
      settle(); check("t5_exc_flush", 32'(hz.flush), 32'h1F);
      advance();
      hz.exception = '0;
      settle(); check("t5_no_abort", 32'(hz.v_kill), 0); check("t5_underflow_held", 32'(hz.v_underflow), 1);
      advance();

`ifdef RV32V_HAZARD_WATCHDOG_EN
      // One op that never retires: the watchdog must abort after WDT_LIM quiet cycles.
      hz.v_start = 1'b1;
      step();
      hz.v_start = 1'b0;
      seen = -1;
      for (int i = 0; i < 40; i++) begin
         settle();
         if (hz.v_kill) begin
            seen = i;
            break;
         end
         advance();
      end
      check("wdt_latency", 32'(seen), 32'(WDT_LIM));
      check("wdt_flag", 32'(hz.wdt_timeout), 1);
      advance();
      settle(); check("wdt_count_cleared", 32'(hz.v_count), 0);
      advance();
`endif

      // Reset asserted in the middle of an abort cycle drops every output at once.
      hz.v_start = 1'b1;
      step();
      hz.v_start = 1'b0; hz.exception = 5'b00001;
      step();
      hz.exception = '0;
      settle(); check("rst_mid_kill", 32'(hz.v_kill), 1);
      hz.busy = '1; hz.exception = '1; hz.v_start = 1'b1; hz.csr_update = 1'b1;
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomized traffic checked cycle by cycle against the model.
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < NS; b++) hz.busy[b] = ($urandom_range(0, 9) == 0);
         hz.exception = '0;
         if ($urandom_range(0, 24) == 0) hz.exception[$urandom_range(0, NS - 1)] = 1'b1;
         hz.csr_update = ($urandom_range(0, 19) == 0);
         hz.v_start    = ($urandom_range(0, 1) == 1);
         hz.v_done     = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32v_hazard_ctrl.md
Name: rv32v_hazard_ctrl

Overview:
- Parametrised stall/flush controller for the vector-capable RV32 pipeline; it generalises the fixed fetch1/fetch2/decode/execute/memory hazard unit to NUM_STAGES stages.
- Adds a credit-tracked window of up to VQ_DEPTH in-flight vector ops, closed by ROB v_done.
- Adds an abort sequence on exception, which kills vector ops in flight.
- Sits beside the pipeline and drives per-stage stall/flush vectors; stage 0 is the oldest fetch stage, NUM_STAGES-1 is the youngest (writeback side).

Parameters:
NUM_STAGES, 5, number of pipeline stages controlled (>=3)
DEC_STAGE, 2, index of the decode stage that issues vector ops (< CSR_STAGE)
CSR_STAGE, 4, index of the stage that commits CSR writes (< NUM_STAGES)
VQ_DEPTH, 4, maximum outstanding vector ops (1..15)
WDT_LIMIT, 1024, watchdog cycle limit (used only with the optional feature)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
busy  in  NUM_STAGES  per-stage busy (stage cannot advance)
exception  in  NUM_STAGES  per-stage exception raised this cycle
csr_update  in  1  CSR write committing in CSR_STAGE
v_start  in  1  decode presents a vector op this cycle
v_done  in  1  ROB retire pulse, one vector op complete
stall  out  NUM_STAGES  per-stage hold
flush  out  NUM_STAGES  per-stage squash
v_busy  out  1  vector window full; decode must hold
v_decode_done  out  1  vector op accepted this cycle
v_kill  out  1  one-cycle pulse: discard all in-flight vector ops
v_count  out  $clog2(VQ_DEPTH+1)  outstanding vector ops
v_underflow  out  1  sticky: v_done received with v_count==0
wdt_timeout  out  1  sticky watchdog flag (tied 0 when the feature is absent)

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, v_count=0, v_underflow=0, wdt_timeout=0. All outputs are 0 while in reset.
- Stall, combinational: stall[i] = OR(busy[j]) over j>i. In addition, stall[i] is set for i<=DEC_STAGE when v_busy is high or state==ABORT.
- Flush, combinational:
  - Let k = the highest index with exception[k]=1. Set flush[i]=1 for all i<=k.
  - csr_update sets flush[i] for all i<CSR_STAGE.
  - flush wins over stall for the same stage.
- Accept: acc = v_start & ~stall[DEC_STAGE] & ~flush[DEC_STAGE] & (state!=ABORT) & (v_count<VQ_DEPTH). v_decode_done = acc.
- Counter, registered:
  - acc and v_done together: v_count unchanged.
  - acc only: v_count+1.
  - v_done only with v_count>0: v_count-1.
  - v_done with v_count==0: ignored; v_underflow set.
  - v_count never exceeds VQ_DEPTH.
- v_busy = (v_count==VQ_DEPTH) | (state==FULL).
- FSM states: IDLE, ACTIVE, FULL, ABORT.
  - IDLE -> ACTIVE when next v_count>0.
  - ACTIVE -> FULL when next v_count==VQ_DEPTH.
  - ACTIVE -> IDLE when next v_count==0.
  - FULL -> ACTIVE on v_done without acc.
  - Any state -> ABORT when any exception bit is set and (v_count>0 or acc).
  - ABORT lasts exactly 1 cycle: v_kill=1, v_count is cleared to 0 at the end of the cycle, and v_done in that cycle is ignored (no underflow). Then -> IDLE.
- Exception with v_count==0 and no acc: flush only, no ABORT.
- Exception and csr_update in the same cycle: flush is the OR of both masks.

Optional Feature:
- Macro: RV32V_HAZARD_WATCHDOG_EN.
- When defined:
  - A cycle counter runs while state is ACTIVE or FULL.
  - It clears on every v_done and on entry to IDLE.
  - On reaching WDT_LIMIT it sets wdt_timeout (sticky until RST) and forces ABORT the next cycle.
- When not defined: no counter is built, wdt_timeout is tied 0, and the WDT_LIMIT parameter is unused.

Decomposition:
- Package rv32v_hazard_pkg: enum hzd_state_t {IDLE, ACTIVE, FULL, ABORT}, plus default stage-index localparams DEC_STAGE_DEF and CSR_STAGE_DEF.
- One natural sub-module, rv32v_vq_credit: the counter, accept logic, underflow flag and FSM. The stall/flush masks stay in the top level as combinational logic.

Test Plan:
1. busy=5'b01000 -> stall=5'b00111, flush=0. Then busy=0 -> stall=0.
2. Four v_start with v_done=0 (default parameters) -> v_decode_done pulses 4 times, v_count=4, v_busy=1, stall[2:0]=1. Then one v_done -> v_count=3, v_busy=0 next cycle.
3. v_count=2, v_start and v_done in the same cycle -> v_count stays 2, v_decode_done=1.
4. v_count=3, exception=5'b01000 -> flush=5'b01111 that cycle; ABORT next cycle with v_kill=1 for 1 cycle; then v_count=0, state=IDLE.
5. v_done with v_count=0 -> v_underflow=1 and held until RST. csr_update=1 -> flush=5'b01111.
6. With the watchdog macro and WDT_LIMIT=16: one v_start, then no v_done for 16 cycles -> wdt_timeout=1, v_kill pulse, v_count=0. Assert RST mid-ABORT -> all outputs 0 immediately.
